// File: rtl/arb_pkg.sv
// Shared constants and state type for the 16-requester round-robin bus arbiter.
package arb_pkg;

  localparam int NUM_REQ = 16;
  localparam int IDX_W   = 4;

  localparam int unsigned DEF_TIMEOUT_CYCLES = 64;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick16.sv
// Combinational round-robin pick: first eligible requester after ptr, wrapping back to ptr.
module rr_pick16
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W:0]      shift;
  logic [2*NUM_REQ-1:0] doubled;
  logic [NUM_REQ-1:0]  rot;
  logic [IDX_W-1:0]    rot_idx;

  // Rotating by ptr+1 puts the highest-priority requester at bit 0.
  assign shift   = {1'b0, ptr} + 5'd1;
  assign doubled = {eligible, eligible} >> shift;
  assign rot     = doubled[NUM_REQ-1:0];
  assign any     = |eligible;

  always_comb begin
    rot_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) rot_idx = IDX_W'(i);
    end
  end

  // 4-bit addition wraps modulo 16, undoing the rotation.
  assign idx    = any ? (rot_idx + ptr + 4'd1) : '0;
  assign onehot = any ? (NUM_REQ'(1) << idx) : '0;

endmodule

// File: rtl/bus_arbiter_16.sv
// Round-robin arbiter for 16 requesters with registered one-hot grant held until release.
// Optional grant-hold watchdog enabled by defining ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no grant; arbitrate among eligible requests this cycle
// GRANT | one owner holds the bus until its req drops (or watchdog fires)
module bus_arbiter_16
  import arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               busy,
  output logic               timeout
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("bus_arbiter_16: TIMEOUT_CYCLES must be in 2..255");
  end

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  rr_pick16 u_pick (
    .eligible (eligible),
    .ptr      (ptr_q),
    .onehot   (pick_onehot),
    .idx      (pick_idx),
    .any      (pick_any)
  );

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

  logic [7:0]         cnt_q, cnt_d;
  logic [NUM_REQ-1:0] lockout_q, lockout_d;
  logic               timeout_q, timeout_d;
  logic               expire;

  assign eligible = req & ~lockout_q;
  assign expire   = (state_q == GRANT) && req[idx_q] && ((cnt_q + 8'd1) == TIMEOUT_LIM);
`else
  assign eligible = req;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    // A requester's lockout only clears once it has let go of its request.
    lockout_d = lockout_q & req;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          grant_d = pick_onehot;
          idx_d   = pick_idx;
          ptr_d   = pick_idx;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      GRANT: begin
        if (!req[idx_q]) begin
          state_d = IDLE;
          grant_d = '0;
          idx_d   = '0;
`ifdef ARB_TIMEOUT_EN
        end else if (expire) begin
          state_d   = IDLE;
          grant_d   = '0;
          idx_d     = '0;
          timeout_d = 1'b1;
          lockout_d = lockout_d | grant_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= 4'd15;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      lockout_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      lockout_q <= lockout_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign grant     = grant_q;
  assign grant_idx = idx_q;
  assign busy      = (state_q == GRANT);

endmodule

// File: tb/tb_bus_arbiter_16.sv
// Directed self-checking bench for bus_arbiter_16; watchdog checks run when ARB_TIMEOUT_EN is defined.
module tb_bus_arbiter_16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] req = '0;
  logic [15:0] grant;
  logic [3:0]  grant_idx;
  logic        busy;
  logic        timeout;

  int n_chk = 0;
  int n_err = 0;

  bus_arbiter_16 #(.TIMEOUT_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .grant     (grant),
    .grant_idx (grant_idx),
    .busy      (busy),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_grant(input string tag, input logic [15:0] g, input logic [3:0] idx, input logic b);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".idx"}, 32'(grant_idx), 32'(idx));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
  endtask

  task automatic do_reset();
    req   = '0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int order [5] = '{0, 5, 10, 15, 0};
    int bad_grant;
    int bad_to;

    #3;
    chk_grant("reset", 16'h0000, 4'd0, 1'b0);
    chk("reset.timeout", 32'(timeout), 32'd0);
    rst_n = 1'b1;

    // Single requester: grant then release.
    req = 16'h0001;
    tick();
    chk_grant("single.grant", 16'h0001, 4'd0, 1'b1);
    req = 16'h0000;
    tick();
    chk_grant("single.release", 16'h0000, 4'd0, 1'b0);

    // Round robin over 0,5,10,15 and back to 0, each owner holding 3 cycles.
    tick();
    do_reset();
    req = 16'h8421;
    tick();
    foreach (order[k]) begin
      chk_grant($sformatf("rr%0d.own", k), 16'(1) << order[k], 4'(order[k]), 1'b1);
      tick(2);
      chk_grant($sformatf("rr%0d.hold", k), 16'(1) << order[k], 4'(order[k]), 1'b1);
      req[order[k]] = 1'b0;
      tick();
      chk_grant($sformatf("rr%0d.idle", k), 16'h0000, 4'd0, 1'b0);
      req[order[k]] = 1'b1;
      tick();
    end

    // Non-owner request is ignored while owner 3 holds.
    do_reset();
    req = 16'h0008;
    tick();
    chk_grant("hold3.grant", 16'h0008, 4'd3, 1'b1);
    req = 16'h0088;
    tick(2);
    chk_grant("hold3.ignore7", 16'h0008, 4'd3, 1'b1);
    req = 16'h0080;
    tick();
    chk_grant("hold3.release", 16'h0000, 4'd0, 1'b0);
    tick();
    chk_grant("hold3.next7", 16'h0080, 4'd7, 1'b1);

    // Asynchronous reset while requester 9 owns the bus.
    req = 16'h0200;
    tick();
    tick();
    chk_grant("own9", 16'h0200, 4'd9, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_grant("async_rst", 16'h0000, 4'd0, 1'b0);
    req = 16'h0201;
    #1;
    rst_n = 1'b1;
    tick();
    chk_grant("post_rst.first0", 16'h0001, 4'd0, 1'b1);

    do_reset();
    req = 16'h0004;
    tick();
    chk_grant("wd.grant", 16'h0004, 4'd2, 1'b1);
`ifdef ARB_TIMEOUT_EN
    tick(3);
    chk_grant("wd.held4", 16'h0004, 4'd2, 1'b1);
    chk("wd.no_pulse_yet", 32'(timeout), 32'd0);
    tick();
    chk_grant("wd.revoked", 16'h0000, 4'd0, 1'b0);
    chk("wd.pulse", 32'(timeout), 32'd1);
    tick();
    chk("wd.pulse_end", 32'(timeout), 32'd0);
    chk_grant("wd.locked", 16'h0000, 4'd0, 1'b0);
    tick();
    chk_grant("wd.still_locked", 16'h0000, 4'd0, 1'b0);
    req = 16'h0000;
    tick();
    req = 16'h0004;
    tick();
    chk_grant("wd.regrant", 16'h0004, 4'd2, 1'b1);
`else
    bad_grant = 0;
    bad_to    = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (grant !== 16'h0004) bad_grant++;
      if (timeout !== 1'b0) bad_to++;
    end
    chk("nowd.hold1000_bad_grants", 32'(bad_grant), 32'd0);
    chk("nowd.timeout_high_cycles", 32'(bad_to), 32'd0);
    chk_grant("nowd.end", 16'h0004, 4'd2, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
